// File: rtl/single_core_proc.sv
// Single-issue multi-cycle accumulator core: FETCH/DECODE/EXEC (+MEM for LOAD)
// with an external instruction RAM and a single-port data RAM.
module single_core_proc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] Instruction,
  input  logic [31:0] Data,
  input  logic [2:0]  coreID,
  output logic [5:0]  PC_out,
  output logic [11:0] AR_out,
  output logic [31:0] DR_out,
  output logic        DRAM_we,
  output logic        End
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_MOV   = 5'b00011;
  localparam logic [4:0] OP_MVAC  = 5'b00100;
  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_MUL   = 5'b00111;
  localparam logic [4:0] OP_LOADI = 5'b01000;
  localparam logic [4:0] OP_INC   = 5'b01001;
  localparam logic [4:0] OP_DEC   = 5'b01010;
  localparam logic [4:0] OP_JUMP  = 5'b01011;
  localparam logic [4:0] OP_JMPNZ = 5'b01100;
  localparam logic [4:0] OP_CLRAC = 5'b01101;
  localparam logic [4:0] OP_END   = 5'b11111;

  localparam logic [3:0] SEL_AC = 4'd0;

  logic [2:0]  state;
  logic [5:0]  pc;
  logic [20:0] ir;
  logic [31:0] ac, dr, tr, ax, cx, rx;
  logic [11:0] ar;
  logic        z;

  logic [4:0]  opcode;
  logic [3:0]  sel;
  logic [11:0] imm;
  logic [31:0] rd_val;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        z_en;

  assign opcode = ir[20:16];
  assign sel    = ir[15:12];
  assign imm    = ir[11:0];

  assign PC_out  = pc;
  assign AR_out  = ar;
  assign DR_out  = dr;
  assign DRAM_we = (state == S_EXEC) && (opcode == OP_STORE);
  assign End     = (state == S_HALT);

  always_comb begin
    rd_val = 32'd0;
    case (sel)
      4'd0: rd_val = ac;
      4'd1: rd_val = dr;
      4'd2: rd_val = tr;
      4'd3: rd_val = {20'd0, ar};
      4'd4: rd_val = ax;
      4'd5: rd_val = cx;
      4'd6: rd_val = rx;
      4'd7: rd_val = {29'd0, coreID};
      default: rd_val = 32'd0;
    endcase
  end

  // One write port: every EXEC-stage register update funnels through wr_sel/wr_data
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = sel;
    wr_data = 32'd0;
    z_en    = 1'b0;
    case (opcode)
      OP_MOV:   begin wr_en = 1'b1; wr_sel = SEL_AC; wr_data = rd_val; end
      OP_MVAC:  begin wr_en = 1'b1; wr_data = ac; end
      OP_ADD:   begin wr_en = 1'b1; wr_sel = SEL_AC; wr_data = ac + rd_val; z_en = 1'b1; end
      OP_SUB:   begin wr_en = 1'b1; wr_sel = SEL_AC; wr_data = ac - rd_val; z_en = 1'b1; end
      OP_MUL:   begin wr_en = 1'b1; wr_sel = SEL_AC; wr_data = ac * rd_val; z_en = 1'b1; end
      OP_LOADI: begin wr_en = 1'b1; wr_data = {20'd0, imm}; end
      OP_INC:   begin wr_en = 1'b1; wr_data = rd_val + 32'd1; z_en = 1'b1; end
      OP_DEC:   begin wr_en = 1'b1; wr_data = rd_val - 32'd1; z_en = 1'b1; end
      OP_CLRAC: begin wr_en = 1'b1; wr_sel = SEL_AC; wr_data = 32'd0; end
      default:  wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= 6'd0;
      ir    <= 21'd0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= Instruction;
          state <= S_DECODE;
        end
        S_DECODE: begin
          pc    <= pc + 6'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (opcode == OP_JUMP || (opcode == OP_JMPNZ && !z))
            pc <= imm[5:0];
          if (opcode == OP_LOAD)
            state <= S_MEM;
          else if (opcode == OP_END)
            state <= S_HALT;
          else
            state <= S_FETCH;
        end
        S_MEM:   state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Selects 7-15 have no storage, so writes to them simply fall through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac <= 32'd0;
      dr <= 32'd0;
      tr <= 32'd0;
      ax <= 32'd0;
      cx <= 32'd0;
      rx <= 32'd0;
      ar <= 12'd0;
      z  <= 1'b0;
    end else if (state == S_EXEC) begin
      if (wr_en) begin
        case (wr_sel)
          4'd0: ac <= wr_data;
          4'd1: dr <= wr_data;
          4'd2: tr <= wr_data;
          4'd3: ar <= wr_data[11:0];
          4'd4: ax <= wr_data;
          4'd5: cx <= wr_data;
          4'd6: rx <= wr_data;
          default: ;
        endcase
      end
      if (z_en)
        z <= (wr_data == 32'd0);
    end else if (state == S_MEM) begin
      dr <= Data;
    end
  end

endmodule

// File: tb/tb_single_core_proc.sv
// Directed bench for single_core_proc: a 64-word program array feeds Instruction
// from PC_out and each task checks one behaviour at hand-computed cycle numbers.
module tb_single_core_proc;

  logic        clk;
  logic        rst_n;
  logic [20:0] Instruction;
  logic [31:0] Data;
  logic [2:0]  coreID;
  logic [5:0]  PC_out;
  logic [11:0] AR_out;
  logic [31:0] DR_out;
  logic        DRAM_we;
  logic        End;

  logic [20:0] imem [0:63];
  int total;
  int bad;
  int cyc;

  single_core_proc dut (
    .clk(clk),
    .rst_n(rst_n),
    .Instruction(Instruction),
    .Data(Data),
    .coreID(coreID),
    .PC_out(PC_out),
    .AR_out(AR_out),
    .DR_out(DR_out),
    .DRAM_we(DRAM_we),
    .End(End)
  );

  assign Instruction = imem[PC_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] enc(input logic [4:0] op, input logic [3:0] sel,
                                      input logic [11:0] imm);
    return {op, sel, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 21'd0;
  endtask

  // Cycle 0 is the negedge at which rst_n is released; cycle k is k negedges later
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    clear_prog();
    Data = 32'd0;
    coreID = 3'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++; if (PC_out !== 6'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d exp=0", PC_out); end
    total++; if (AR_out !== 12'd0) begin bad++; $display("[TB] FAIL reset_ar got=%0d exp=0", AR_out); end
    total++; if (DR_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_dr got=%0h exp=0", DR_out); end
    total++; if (DRAM_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b exp=0", DRAM_we); end
    total++; if (End !== 1'b0) begin bad++; $display("[TB] FAIL reset_end got=%b exp=0", End); end
  endtask

  task automatic test_loadi_hold();
    clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = enc(5'b01000, 4'd5, 12'd34);
    Data = 32'd5;
    do_reset();
    total++; if (PC_out !== 6'd0) begin bad++; $display("[TB] FAIL hold_pc0 got=%0d exp=0", PC_out); end
    for (int c = 1; c <= 9; c++) begin
      tick();
      total++; if (DRAM_we !== 1'b0) begin bad++; $display("[TB] FAIL hold_we cyc=%0d got=%b exp=0", cyc, DRAM_we); end
      total++; if (End !== 1'b0) begin bad++; $display("[TB] FAIL hold_end cyc=%0d got=%b exp=0", cyc, End); end
      if (c == 3) begin
        total++; if (PC_out !== 6'd1) begin bad++; $display("[TB] FAIL hold_pc1 got=%0d exp=1", PC_out); end
        total++; if (dut.cx !== 32'd34) begin bad++; $display("[TB] FAIL hold_cx got=%0d exp=34", dut.cx); end
      end
      if (c == 6) begin
        total++; if (PC_out !== 6'd2) begin bad++; $display("[TB] FAIL hold_pc2 got=%0d exp=2", PC_out); end
      end
    end
  endtask

  task automatic test_store();
    int we_cnt;
    int we_cyc;
    logic [11:0] ar_seen;
    logic [31:0] dr_seen;
    clear_prog();
    imem[0] = enc(5'b01000, 4'd3, 12'd7);
    imem[1] = enc(5'b01000, 4'd1, 12'd99);
    imem[2] = enc(5'b00010, 4'd0, 12'd0);
    we_cnt = 0; we_cyc = -1; ar_seen = '0; dr_seen = '0;
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (DRAM_we === 1'b1) begin
        we_cnt++; we_cyc = cyc; ar_seen = AR_out; dr_seen = DR_out;
      end
    end
    total++; if (we_cnt != 1) begin bad++; $display("[TB] FAIL store_we_count got=%0d exp=1", we_cnt); end
    total++; if (we_cyc != 8) begin bad++; $display("[TB] FAIL store_we_cycle got=%0d exp=8", we_cyc); end
    total++; if (ar_seen !== 12'd7) begin bad++; $display("[TB] FAIL store_addr got=%0d exp=7", ar_seen); end
    total++; if (dr_seen !== 32'd99) begin bad++; $display("[TB] FAIL store_data got=%0d exp=99", dr_seen); end
  endtask

  task automatic test_load();
    clear_prog();
    imem[0] = enc(5'b01000, 4'd3, 12'd3);
    imem[1] = enc(5'b00001, 4'd0, 12'd0);
    Data = 32'hDEADBEEF;
    do_reset();
    repeat (6) tick();
    total++; if (AR_out !== 12'd3) begin bad++; $display("[TB] FAIL load_ar_mem got=%0d exp=3", AR_out); end
    total++; if (DR_out !== 32'd0) begin bad++; $display("[TB] FAIL load_dr_early got=%0h exp=0", DR_out); end
    tick();
    total++; if (DR_out !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_dr got=%0h exp=deadbeef", DR_out); end
    total++; if (PC_out !== 6'd2) begin bad++; $display("[TB] FAIL load_next_pc got=%0d exp=2", PC_out); end
  endtask

  task automatic test_alu();
    clear_prog();
    imem[0] = enc(5'b01000, 4'd0, 12'd10);
    imem[1] = enc(5'b01000, 4'd2, 12'd3);
    imem[2] = enc(5'b00110, 4'd2, 12'd0);
    imem[3] = enc(5'b00101, 4'd2, 12'd0);
    imem[4] = enc(5'b01001, 4'd0, 12'd0);
    imem[5] = enc(5'b01101, 4'd0, 12'd0);
    imem[6] = enc(5'b00110, 4'd2, 12'd0);
    imem[7] = enc(5'b11111, 4'd0, 12'd0);
    do_reset();
    repeat (9) tick();
    total++; if (dut.ac !== 32'd7) begin bad++; $display("[TB] FAIL alu_sub got=%0d exp=7", dut.ac); end
    repeat (3) tick();
    total++; if (dut.ac !== 32'd10) begin bad++; $display("[TB] FAIL alu_add got=%0d exp=10", dut.ac); end
    repeat (3) tick();
    total++; if (dut.ac !== 32'd11) begin bad++; $display("[TB] FAIL alu_inc got=%0d exp=11", dut.ac); end
    repeat (3) tick();
    total++; if (dut.ac !== 32'd0) begin bad++; $display("[TB] FAIL alu_clrac got=%0d exp=0", dut.ac); end
    total++; if (dut.z !== 1'b0) begin bad++; $display("[TB] FAIL alu_clrac_z got=%b exp=0", dut.z); end
    repeat (3) tick();
    total++; if (dut.ac !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL alu_sub_wrap got=%0h exp=fffffffd", dut.ac); end
  endtask

  task automatic test_loop();
    int body_cnt;
    logic [5:0] prev_pc;
    clear_prog();
    imem[0] = enc(5'b01000, 4'd4, 12'd3);
    imem[1] = enc(5'b00011, 4'd4, 12'd0);
    imem[2] = enc(5'b01010, 4'd4, 12'd0);
    imem[3] = enc(5'b01100, 4'd0, 12'd2);
    imem[4] = enc(5'b01000, 4'd6, 12'd77);
    imem[5] = enc(5'b11111, 4'd0, 12'd0);
    do_reset();
    body_cnt = 0;
    prev_pc = PC_out;
    while (End !== 1'b1 && cyc < 100) begin
      tick();
      if (PC_out == 6'd2 && prev_pc != 6'd2) body_cnt++;
      prev_pc = PC_out;
    end
    total++; if (End !== 1'b1) begin bad++; $display("[TB] FAIL loop_timeout got=%b exp=1", End); end
    total++; if (cyc != 30) begin bad++; $display("[TB] FAIL loop_cycles got=%0d exp=30", cyc); end
    total++; if (body_cnt != 3) begin bad++; $display("[TB] FAIL loop_iterations got=%0d exp=3", body_cnt); end
    total++; if (dut.z !== 1'b1) begin bad++; $display("[TB] FAIL loop_z got=%b exp=1", dut.z); end
    total++; if (dut.ax !== 32'd0) begin bad++; $display("[TB] FAIL loop_ax got=%0d exp=0", dut.ax); end
    total++; if (dut.rx !== 32'd77) begin bad++; $display("[TB] FAIL loop_fallthrough got=%0d exp=77", dut.rx); end
    total++; if (PC_out !== 6'd6) begin bad++; $display("[TB] FAIL loop_pc got=%0d exp=6", PC_out); end
  endtask

  task automatic test_end();
    clear_prog();
    imem[0] = enc(5'b00011, 4'd7, 12'd0);
    imem[1] = enc(5'b11111, 4'd0, 12'd0);
    coreID = 3'd5;
    do_reset();
    while (End !== 1'b1 && cyc < 20) tick();
    total++; if (cyc != 6) begin bad++; $display("[TB] FAIL end_cycle got=%0d exp=6", cyc); end
    total++; if (dut.ac !== 32'd5) begin bad++; $display("[TB] FAIL end_ac got=%0d exp=5", dut.ac); end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if (End !== 1'b1) begin bad++; $display("[TB] FAIL halt_end cyc=%0d got=%b exp=1", cyc, End); end
      total++; if (PC_out !== 6'd2) begin bad++; $display("[TB] FAIL halt_pc cyc=%0d got=%0d exp=2", cyc, PC_out); end
      total++; if (DRAM_we !== 1'b0) begin bad++; $display("[TB] FAIL halt_we cyc=%0d got=%b exp=0", cyc, DRAM_we); end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (End !== 1'b0) begin bad++; $display("[TB] FAIL end_reset got=%b exp=0", End); end
    total++; if (PC_out !== 6'd0) begin bad++; $display("[TB] FAIL end_reset_pc got=%0d exp=0", PC_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_wrap();
    clear_prog();
    imem[0] = enc(5'b01000, 4'd0, 12'd256);
    imem[1] = enc(5'b01000, 4'd2, 12'd256);
    imem[2] = enc(5'b00111, 4'd2, 12'd0);
    imem[3] = enc(5'b00100, 4'd2, 12'd0);
    imem[4] = enc(5'b00111, 4'd2, 12'd0);
    imem[5] = enc(5'b01011, 4'd0, 12'd63);
    do_reset();
    repeat (9) tick();
    total++; if (dut.ac !== 32'h00010000) begin bad++; $display("[TB] FAIL mul_first got=%0h exp=10000", dut.ac); end
    total++; if (dut.z !== 1'b0) begin bad++; $display("[TB] FAIL mul_first_z got=%b exp=0", dut.z); end
    repeat (6) tick();
    total++; if (dut.ac !== 32'd0) begin bad++; $display("[TB] FAIL mul_wrap got=%0h exp=0", dut.ac); end
    total++; if (dut.z !== 1'b1) begin bad++; $display("[TB] FAIL mul_wrap_z got=%b exp=1", dut.z); end
    repeat (3) tick();
    total++; if (PC_out !== 6'd63) begin bad++; $display("[TB] FAIL jump_pc got=%0d exp=63", PC_out); end
    repeat (2) tick();
    total++; if (PC_out !== 6'd0) begin bad++; $display("[TB] FAIL pc_wrap got=%0d exp=0", PC_out); end
  endtask

  task automatic test_async_reset();
    clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = enc(5'b01000, 4'd1, 12'd99);
    do_reset();
    repeat (4) tick();
    total++; if (DR_out !== 32'd99) begin bad++; $display("[TB] FAIL async_pre_dr got=%0d exp=99", DR_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (DR_out !== 32'd0) begin bad++; $display("[TB] FAIL async_dr got=%0d exp=0", DR_out); end
    total++; if (PC_out !== 6'd0) begin bad++; $display("[TB] FAIL async_pc got=%0d exp=0", PC_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    Data = 32'd0;
    coreID = 3'd0;
    rst_n = 1'b1;
    test_reset();
    test_loadi_hold();
    test_store();
    test_load();
    test_alu();
    test_loop();
    test_end();
    test_mul_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/single_core_proc.md
SINGLE_CORE_PROC -- requirements
Module: single_core_proc

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 Instruction  input  21  instruction word from external instruction RAM, addressed by PC_out (combinational read).
REQ-004 Data  input  32  read data from external data RAM, addressed by AR_out.
REQ-005 coreID  input  3  core identifier, readable as register ID.
REQ-006 PC_out  output  6  program counter register.
REQ-007 AR_out  output  12  address register, data RAM address.
REQ-008 DR_out  output  32  data register, data RAM write data.
REQ-009 DRAM_we  output  1  data RAM write enable.
REQ-010 End  output  1  program halted.

Function
REQ-011 Instruction fields: [20:16] opcode, [15:12] register select SEL, [11:0] immediate IMM.
REQ-012 SEL map: 0 AC, 1 DR, 2 TR, 3 AR, 4 Ax, 5 Cx, 6 Rx, 7 ID (read-only, {29'b0,coreID}); 8-15 read 0, writes ignored; writes to ID ignored.
REQ-013 AC, DR, TR, Ax, Cx, Rx are 32-bit; AR is 12-bit; reads of AR zero-extend; writes to AR keep the low 12 bits.
REQ-014 Opcodes: 00000 NOP; 00001 LOAD DR<=Data; 00010 STORE mem[AR]<=DR; 00011 MOV AC<=reg[SEL]; 00100 MVAC reg[SEL]<=AC; 00101 ADD AC<=AC+reg[SEL]; 00110 SUB AC<=AC-reg[SEL]; 00111 MUL AC<=low 32 bits of AC*reg[SEL].
REQ-015 Opcodes: 01000 LOADI reg[SEL]<=zero-extended IMM; 01001 INC reg[SEL]+=1; 01010 DEC reg[SEL]-=1; 01011 JUMP PC<=IMM[5:0]; 01100 JMPNZ PC<=IMM[5:0] if Z==0; 01101 CLRAC AC<=0; 11111 END; all other opcodes execute as NOP.
REQ-016 All arithmetic is unsigned modulo 2^32; carry/overflow discarded.
REQ-017 Z flag updates on ADD, SUB, MUL, INC and DEC: set iff the 32-bit result is 0; all other instructions leave Z unchanged.
REQ-018 State machine: FETCH -> DECODE -> EXEC -> (MEM for LOAD only) -> FETCH; END in EXEC -> HALT.
REQ-019 FETCH: PC_out=PC; Instruction sampled into IR on the rising edge ending FETCH.
REQ-020 DECODE: PC<=PC+1, wrapping 63 -> 0.
REQ-021 EXEC: register, ALU and branch results are written on the rising edge ending EXEC; a taken JUMP/JMPNZ overrides the DECODE increment.
REQ-022 Latency: 3 cycles per instruction; LOAD takes 4 cycles.
REQ-023 STORE: DRAM_we=1 for exactly the EXEC cycle, with AR_out=AR and DR_out=DR stable in that cycle; DRAM_we=0 in all other cycles.
REQ-024 LOAD: AR_out=AR is held through EXEC and MEM; DR<=Data on the rising edge ending MEM.
REQ-025 HALT: End=1, DRAM_we=0, all registers frozen; HALT is left only by reset.
REQ-026 PC_out, AR_out and DR_out are driven directly from their registers (no combinational path from inputs).

Reset
REQ-027 While rst_n=0, asynchronously: PC=0, AR=0, IR=0, every 32-bit register=0, Z=0, state=FETCH, End=0, DRAM_we=0.
REQ-028 Reset asserted mid-instruction aborts that instruction with no register or memory write; after rst_n rises, fetch starts at PC=0 on the next rising edge.

Verification
REQ-029 Reset, then Instruction held at 21'b01000_0101_000000100010 (LOADI Cx,34) with Data=5 -> Cx=34 after the first EXEC; PC_out goes 0,1,2 every 3 cycles; DRAM_we stays 0; End stays 0.
REQ-030 Program LOADI AR,7; LOADI DR,99; STORE -> exactly one cycle of DRAM_we=1, with AR_out=7 and DR_out=99 in that cycle.
REQ-031 LOADI AR,3; LOAD with Data=0xDEADBEEF -> DR_out=0xDEADBEEF 4 cycles after the LOAD fetch.
REQ-032 LOADI Ax,3; MOV Ax; then DEC Ax; JMPNZ to the DEC -> loop body runs 3 times; Z=1 on exit; PC falls through to the next instruction.
REQ-033 coreID=5; MOV ID; END -> AC=5; End=1 from the END EXEC onward; PC frozen; rst_n pulse -> End=0, PC_out=0.
REQ-034 MUL with AC=0x10000 and reg=0x10000 -> AC=0, Z=1; PC=63 plus one DECODE -> PC_out=0.
